// File: rtl/debug_load_sink.sv
`default_nettype none
// ============================================================================
// Module   : debug_load_sink
// Brief    : Debug-port instruction loader. Collects instruction words into a
//            local RAM while the core is held, then releases the core and
//            serves its fetches with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module debug_load_sink #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DEBUG_SIG,
  input  logic [31:0]   DEBUG_addr,
  input  logic [31:0]   DEBUG_instr,
  input  logic          START,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          core_en,
  output logic [AW:0]   load_count,
  output logic          load_err,
  output logic          seq_warn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [31:0]       exp_addr;

  logic              loading;
  logic              addr_in_range;
  logic              wr_ok;
  logic              wr_oob;
  logic [AW-1:0]     widx;
  logic [AW-1:0]     fidx;
  logic              fetch_hit;
  logic              unused_fetch_lsbs;

  // Write qualification: only while the core is held and the address fits.
  assign loading       = (state == IDLE) || (state == LOAD);
  assign addr_in_range = (DEBUG_addr[31:AW] == '0);
  assign wr_ok         = DEBUG_SIG && loading && addr_in_range;
  assign wr_oob        = DEBUG_SIG && loading && !addr_in_range;
  assign widx          = DEBUG_addr[AW-1:0];

  // Fetch side: byte PC to word index; upper bits must be clear to hit.
  assign fidx      = fetch_addr[AW+1:2];
  assign fetch_hit = (state == RUN) && (fetch_addr[31:AW+2] == '0) && valid[fidx];

  // Byte offset within the word is irrelevant to word fetches.
  assign unused_fetch_lsbs = ^fetch_addr[1:0];

  // RAM data needs no reset; the valid bits hide anything stale.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[widx] <= DEBUG_instr;
    end
  end

  // Control FSM with registered status outputs, load bookkeeping and fetch port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      load_count  <= '0;
      exp_addr    <= '0;
      load_err    <= 1'b0;
      seq_warn    <= 1'b0;
      core_en     <= 1'b0;
      fetch_instr <= NOP_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (wr_oob) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else if (START) begin
            if (wr_ok) begin
              state   <= RUN;
              core_en <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end else if (wr_ok) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (wr_oob) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else if (START) begin
            state   <= RUN;
            core_en <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase

      if (wr_ok) begin
        valid[widx] <= 1'b1;
        if (!valid[widx]) begin
          load_count <= load_count + (AW+1)'(1);
        end
        if (DEBUG_addr != exp_addr) begin
          seq_warn <= 1'b1;
        end
        exp_addr <= DEBUG_addr + 32'd1;
      end

      fetch_instr <= fetch_hit ? mem[fidx] : NOP_WORD;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_load_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_load_sink
// Brief    : Self-checking bench for debug_load_sink: fetch vectors from a
//            table through a scoreboard queue, plus hand-written sequences
//            for load, overwrite, error and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_load_sink;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        DEBUG_SIG;
  logic [31:0] DEBUG_addr;
  logic [31:0] DEBUG_instr;
  logic        START;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        core_en;
  logic [8:0]  load_count;
  logic        load_err;
  logic        seq_warn;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fvec_t;

  fvec_t run_vec[8];

  debug_load_sink dut (
    .clk         (clk),
    .rst         (rst),
    .DEBUG_SIG   (DEBUG_SIG),
    .DEBUG_addr  (DEBUG_addr),
    .DEBUG_instr (DEBUG_instr),
    .START       (START),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .core_en     (core_en),
    .load_count  (load_count),
    .load_err    (load_err),
    .seq_warn    (seq_warn)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input int k);
    return 32'hA5000000 + 32'(k) * 32'h00010101;
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic st);
    DEBUG_SIG   = 1'b1;
    DEBUG_addr  = a;
    DEBUG_instr = d;
    START       = st;
    tick();
    DEBUG_SIG   = 1'b0;
    START       = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive a fetch, queue its expectation, compare after the one-cycle latency.
  task automatic do_fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] want;
    fetch_addr = a;
    sb_q.push_back(exp);
    tick();
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s actual=empty_queue required=entry", name);
    end else begin
      want = sb_q.pop_front();
      chk(name, fetch_instr, want);
    end
  endtask

  task automatic chk_status(input string tag, input logic ce, input logic [8:0] cnt,
                            input logic le, input logic sw);
    chk({tag, "_core_en"},    {31'd0, core_en},  {31'd0, ce});
    chk({tag, "_load_count"}, {23'd0, load_count}, {23'd0, cnt});
    chk({tag, "_load_err"},   {31'd0, load_err}, {31'd0, le});
    chk({tag, "_seq_warn"},   {31'd0, seq_warn}, {31'd0, sw});
  endtask

  initial begin
    run_vec[0] = '{32'h00000024, instr_of(9)};
    run_vec[1] = '{32'h00000000, instr_of(0)};
    run_vec[2] = '{32'h00000014, instr_of(5)};
    run_vec[3] = '{32'h00000027, instr_of(9)};
    run_vec[4] = '{32'h00000040, NOP};
    run_vec[5] = '{32'h00000400, NOP};
    run_vec[6] = '{32'h000003FC, NOP};
    run_vec[7] = '{32'h10000024, NOP};

    rst         = 1'b1;
    DEBUG_SIG   = 1'b0;
    DEBUG_addr  = '0;
    DEBUG_instr = '0;
    START       = 1'b0;
    fetch_addr  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_status("reset", 1'b0, 9'd0, 1'b0, 1'b0);
    chk("reset_fetch_instr", fetch_instr, NOP);

    // Sequential load of words 0..9, then release
    for (int k = 0; k < 10; k++) write_word(32'(k), instr_of(k), 1'b0);
    chk_status("seq_loaded", 1'b0, 9'd10, 1'b0, 1'b0);
    pulse_start();
    chk_status("seq_run", 1'b1, 9'd10, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_fetch($sformatf("run_vec%0d", i), run_vec[i].addr, run_vec[i].exp);

    // Write protect in RUN, START level irrelevant
    write_word(32'h0, 32'hDEADBEEF, 1'b1);
    chk_status("run_wp", 1'b1, 9'd10, 1'b0, 1'b0);
    do_fetch("run_wp_fetch0", 32'h0, instr_of(0));

    // Mid-run reset discards everything
    do_reset();
    chk_status("rst_run", 1'b0, 9'd0, 1'b0, 1'b0);
    chk("rst_run_fetch_instr", fetch_instr, NOP);
    do_fetch("rst_run_fetch24", 32'h24, NOP);

    // Overwrite and gap
    write_word(32'h0, 32'h11111111, 1'b0);
    write_word(32'h1, 32'h22222222, 1'b0);
    write_word(32'h1, 32'h33333333, 1'b0);
    write_word(32'h5, 32'h55555555, 1'b0);
    chk_status("ovr_loaded", 1'b0, 9'd3, 1'b0, 1'b1);
    pulse_start();
    chk_status("ovr_run", 1'b1, 9'd3, 1'b0, 1'b1);
    do_fetch("ovr_fetch1", 32'h4,  32'h33333333);
    do_fetch("ovr_fetch5", 32'h14, 32'h55555555);
    do_fetch("ovr_stale2", 32'h8,  NOP);

    // START with nothing loaded -> ERROR, then stuck
    do_reset();
    pulse_start();
    chk_status("err_start", 1'b0, 9'd0, 1'b1, 1'b0);
    write_word(32'h0, 32'h12345678, 1'b1);
    chk_status("err_start_stuck", 1'b0, 9'd0, 1'b1, 1'b0);
    do_fetch("err_start_fetch", 32'h0, NOP);

    // Out-of-range load address -> ERROR, count kept, then stuck
    do_reset();
    write_word(32'h0, 32'hCAFE0000, 1'b0);
    write_word(32'd256, 32'hCAFE0100, 1'b0);
    chk_status("err_oob", 1'b0, 9'd1, 1'b1, 1'b0);
    write_word(32'h1, 32'hCAFE0001, 1'b0);
    pulse_start();
    chk_status("err_oob_stuck", 1'b0, 9'd1, 1'b1, 1'b0);

    // Out-of-range write together with START: ERROR wins
    do_reset();
    write_word(32'h0, 32'h0BAD0000, 1'b0);
    write_word(32'h00010000, 32'h0BAD0001, 1'b1);
    chk_status("err_oob_start", 1'b0, 9'd1, 1'b1, 1'b0);

    // Write and START together from IDLE; non-zero first address warns
    do_reset();
    write_word(32'h3, 32'hFEED0003, 1'b1);
    chk_status("idle_wr_start", 1'b1, 9'd1, 1'b0, 1'b1);
    do_fetch("idle_wr_start_fetch", 32'hC, 32'hFEED0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_load_sink.md
DEBUG_LOAD_SINK -- requirements
Module: debug_load_sink

Interface
REQ-001 Parameter DEPTH, default 256, meaning instruction-RAM depth in 32-bit words (power of two).
REQ-002 Parameter AW, default 8, meaning word-address width, log2(DEPTH).
REQ-003 Parameter NOP_WORD, default 32'h00000013, meaning value returned for unloaded or blocked fetches.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 DEBUG_SIG  input  1  load strobe; one word written per cycle while high.
REQ-007 DEBUG_addr  input  32  word address (not byte) of DEBUG_instr.
REQ-008 DEBUG_instr  input  32  instruction word to store.
REQ-009 START  input  1  level; loader finished, release core.
REQ-010 fetch_addr  input  32  core byte PC; word index = fetch_addr[AW+1:2].
REQ-011 fetch_instr  output  32  registered fetch data.
REQ-012 core_en  output  1  high only in RUN; core stalls while low.
REQ-013 load_count  output  AW+1  number of distinct words written since reset.
REQ-014 load_err  output  1  sticky; high only in ERROR.
REQ-015 seq_warn  output  1  sticky; non-sequential load address seen.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN and ERROR, with one state register.
REQ-017 A write is accepted when DEBUG_SIG=1, state is IDLE or LOAD, and DEBUG_addr[31:AW]==0.
- Write stores mem[DEBUG_addr[AW-1:0]] and sets valid[idx].
REQ-018 load_count SHALL increment by 1 on an accepted write only if valid[idx] was 0; overwriting a word rewrites data and leaves the count unchanged.
REQ-019 An expected-address register SHALL start at 0 after reset and become DEBUG_addr+1 after each accepted write.
- An accepted write whose address differs from it sets seq_warn; the write still completes.
REQ-020 DEBUG_SIG=1 with DEBUG_addr[31:AW]!=0 in IDLE or LOAD SHALL drop the write and enter ERROR next cycle.
REQ-021 State transitions:
- IDLE -> LOAD on an accepted write.
- IDLE -> ERROR on START=1 with no accepted write that cycle.
- LOAD -> RUN on START=1.
- LOAD stays LOAD while DEBUG_SIG=0 and START=0.
REQ-022 DEBUG_SIG=1 and START=1 in the same cycle in LOAD or IDLE SHALL complete the write (if accepted) and enter RUN; the out-of-range rule (REQ-020) takes priority and enters ERROR.
REQ-023 RUN SHALL persist regardless of START level; DEBUG_SIG in RUN SHALL be ignored: no write, no count change, no flag change.
REQ-024 ERROR SHALL be exited only by rst; writes are ignored and core_en=0 in ERROR.
REQ-025 core_en SHALL be high from the first cycle after the RUN transition edge.
REQ-026 Fetch latency SHALL be 1 cycle: fetch_instr at edge N+1 reflects fetch_addr at edge N.
- Returns mem[idx] when state is RUN and valid[idx]=1; otherwise returns NOP_WORD.
REQ-027 fetch_addr[31:AW+2]!=0 in RUN SHALL return NOP_WORD; fetch_addr[1:0] SHALL be ignored.
REQ-028 A write and a fetch to the same index in one cycle cannot occur, because writes and RUN are mutually exclusive.

Reset
REQ-029 rst=1 at an edge SHALL set:
- state=IDLE, all valid bits=0, load_count=0, expected address=0;
- load_err=0, seq_warn=0, core_en=0, fetch_instr=NOP_WORD.
REQ-030 RAM data contents SHALL NOT require reset; the valid bits mask stale data.
REQ-031 rst asserted mid-load or mid-run SHALL take effect at the next edge, discarding all progress; rst has priority over every input.

Verification
REQ-032 Sequential load: addresses 0..9 with instrs I0..I9, then START=1 -> RUN one cycle later, core_en=1, load_count=10, seq_warn=0; fetch_addr=0x24 returns I9 one cycle later.
REQ-033 Unloaded fetch: after REQ-032, fetch_addr=0x40 -> fetch_instr=32'h00000013; fetch_addr=0x400 -> 32'h00000013.
REQ-034 Overwrite and gap: writes to addresses 0, 1, 1, 5 -> load_count=3, seq_warn=1, mem[1] holds the last value; START -> RUN with load_err=0.
REQ-035 Errors:
- START=1 with no prior writes -> ERROR, load_err=1, core_en=0.
- Separately, DEBUG_addr=256 with DEBUG_SIG=1 -> ERROR, load_count unchanged.
- In both cases, later writes and START have no effect until rst.
REQ-036 Write protect and reset: in RUN, DEBUG_SIG=1 to address 0 with a new value -> fetch of 0x0 still returns the original word; then rst=1 for one cycle -> all outputs at REQ-029 values, and fetch returns NOP_WORD until a new load and START.
